// File: rtl/vsi_resp_tx.sv
// vsi_resp_tx: response-frame transmitter for the VSI serial link.
// Sends marker, flag, length hi/lo, payload bytes read from the payload RAM,
// and a CRC-16/CCITT trailer as 11-bit async frames
// (start 0, 8 data bits LSB first, odd parity, stop 1, optional idle gap bits).
// Payload bytes are prefetched one byte ahead so frames stay back-to-back on the bit grid.

module vsi_resp_tx #(
    parameter int CLK_PER_BIT = 12,
    parameter int GAP_BITS    = 0,
    parameter int MAX_LEN     = 2032,
    parameter int AW          = 11
) (
    input  logic          bb_clk_in,
    input  logic          rst_h,
    input  logic          start,
    input  logic [7:0]    marker_in,
    input  logic [7:0]    flag_in,
    input  logic [15:0]   len_in,
    output logic          pl_rd_req,
    output logic [AW-1:0] pl_rd_addr,
    input  logic [7:0]    pl_rd_data,
    output logic          DATA,
    output logic          busy,
    output logic          byte_done,
    output logic          done,
    output logic          len_err
);

    // Bit-period counter, gap counter and byte index widths.
    // The byte index must hold MAX_LEN + 5; 12 bits cover the 2032-byte maximum.
    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam int KW = 12;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE   = CW'(CLK_PER_BIT - 2);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);
    localparam logic [15:0]   MAX_LEN_W = 16'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_BITS   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        odd_parity = ~^data;
    endfunction

    // One byte of CRC-16/CCITT (poly 0x1021, MSB first, no reflection).
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc16_upd = c;
    endfunction

    state_t          state_r;
    logic [CW-1:0]   clk_cnt_r;
    logic [2:0]      bit_idx_r;
    logic [GW-1:0]   gap_cnt_r;
    logic [KW-1:0]   byte_idx_r;
    logic [7:0]      shreg_r;
    logic            par_r;
    logic [7:0]      marker_r;
    logic [7:0]      flag_r;
    logic [15:0]     len_r;
    logic [7:0]      next_byte_r;
    logic            rd_lat_r;
    logic [15:0]     crc_r;

    logic [KW-1:0]   len_k_s;
    logic [KW-1:0]   next_k_s;
    logic [KW-1:0]   pf_addr_s;
    logic            tick_s;
    logic            pre_tick_s;
    logic            last_k_s;
    logic            final_period_s;
    logic            crc_en_s;
    logic            pf_s;
    logic [7:0]      next_byte_s;

    assign len_k_s = len_r[KW-1:0];

    // Bit-grid timing and packet-position decodes.
    always_comb begin
        next_k_s  = byte_idx_r + 12'd1;
        pf_addr_s = next_k_s - 12'd3;
        tick_s    = (clk_cnt_r == CNT_LAST);
        pre_tick_s = (clk_cnt_r == CNT_PRE);
        last_k_s  = (byte_idx_r == (len_k_s + 12'd5));
        crc_en_s  = (byte_idx_r <= (len_k_s + 12'd3));
        // Byte k+1 is payload when 4 <= k+1 <= 3+len, i.e. 3 <= k+1-1... expressed on k+1 here
        if ((next_k_s >= 12'd3) && (next_k_s <= (len_k_s + 12'd2))) begin
            pf_s = 1'b1;
        end else begin
            pf_s = 1'b0;
        end
        if ((state_r == ST_STOP) && (GAP_BITS == 0)) begin
            final_period_s = 1'b1;
        end else if ((state_r == ST_GAP) && (gap_cnt_r == GAP_LAST)) begin
            final_period_s = 1'b1;
        end else begin
            final_period_s = 1'b0;
        end
    end

    // Source of the byte that follows the current one in the packet.
    always_comb begin
        next_byte_s = crc_r[7:0];
        if (next_k_s < 12'd4) begin
            case (next_k_s[1:0])
                2'd0:    next_byte_s = marker_r;
                2'd1:    next_byte_s = flag_r;
                2'd2:    next_byte_s = len_r[15:8];
                default: next_byte_s = len_r[7:0];
            endcase
        end else if (next_k_s <= (len_k_s + 12'd3)) begin
            next_byte_s = next_byte_r;
        end else if (next_k_s == (len_k_s + 12'd4)) begin
            next_byte_s = crc_r[15:8];
        end else begin
            next_byte_s = crc_r[7:0];
        end
    end

    // Transmit FSM with registered line, status pulses and RAM read strobe.
    always_ff @(posedge bb_clk_in or posedge rst_h) begin
        if (rst_h) begin
            state_r     <= ST_IDLE;
            clk_cnt_r   <= {CW{1'b0}};
            bit_idx_r   <= 3'd0;
            gap_cnt_r   <= {GW{1'b0}};
            byte_idx_r  <= {KW{1'b0}};
            shreg_r     <= 8'h00;
            par_r       <= 1'b0;
            marker_r    <= 8'h00;
            flag_r      <= 8'h00;
            len_r       <= 16'h0000;
            next_byte_r <= 8'h00;
            rd_lat_r    <= 1'b0;
            crc_r       <= 16'hFFFF;
            pl_rd_req   <= 1'b0;
            pl_rd_addr  <= {AW{1'b0}};
            DATA        <= 1'b1;
            busy        <= 1'b0;
            byte_done   <= 1'b0;
            done        <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            pl_rd_req <= 1'b0;
            byte_done <= 1'b0;
            done      <= 1'b0;
            len_err   <= 1'b0;

            // RAM data is valid the cycle after the strobe
            rd_lat_r <= pl_rd_req;
            if (rd_lat_r) begin
                next_byte_r <= pl_rd_data;
            end

            if ((state_r == ST_IDLE) || (state_r == ST_DONE) || tick_s) begin
                clk_cnt_r <= {CW{1'b0}};
            end else begin
                clk_cnt_r <= clk_cnt_r + CW'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    busy <= 1'b0;
                    DATA <= 1'b1;
                    if (start) begin
                        if (len_in > MAX_LEN_W) begin
                            len_err <= 1'b1;
                        end else begin
                            marker_r   <= marker_in;
                            flag_r     <= flag_in;
                            len_r      <= len_in;
                            crc_r      <= 16'hFFFF;
                            byte_idx_r <= {KW{1'b0}};
                            shreg_r    <= marker_in;
                            par_r      <= odd_parity(marker_in);
                            DATA       <= 1'b0;
                            busy       <= 1'b1;
                            state_r    <= ST_START;
                        end
                    end
                end

                ST_START: begin
                    // CRC covers header and payload, updated once per byte on its first start-bit cycle
                    if ((clk_cnt_r == {CW{1'b0}}) && crc_en_s) begin
                        crc_r <= crc16_upd(crc_r, shreg_r);
                    end
                    if (tick_s) begin
                        DATA      <= shreg_r[0];
                        bit_idx_r <= 3'd0;
                        state_r   <= ST_BITS;
                    end
                end

                ST_BITS: begin
                    if (tick_s) begin
                        if (bit_idx_r == 3'd7) begin
                            DATA    <= par_r;
                            state_r <= ST_PARITY;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            shreg_r   <= {1'b0, shreg_r[7:1]};
                            DATA      <= shreg_r[1];
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick_s) begin
                        DATA    <= 1'b1;
                        state_r <= ST_STOP;
                    end
                end

                ST_STOP, ST_GAP: begin
                    if (pre_tick_s && final_period_s) begin
                        byte_done <= 1'b1;
                    end
                    if (tick_s) begin
                        if (final_period_s) begin
                            if (last_k_s) begin
                                done    <= 1'b1;
                                state_r <= ST_DONE;
                            end else begin
                                byte_idx_r <= next_k_s;
                                shreg_r    <= next_byte_s;
                                par_r      <= odd_parity(next_byte_s);
                                DATA       <= 1'b0;
                                state_r    <= ST_START;
                                if (pf_s) begin
                                    pl_rd_req  <= 1'b1;
                                    pl_rd_addr <= AW'(pf_addr_s);
                                end
                            end
                        end else if (state_r == ST_STOP) begin
                            gap_cnt_r <= {GW{1'b0}};
                            state_r   <= ST_GAP;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + GW'(1);
                        end
                    end
                end

                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    DATA    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vsi_resp_tx.sv
// Directed bench for vsi_resp_tx: three instances (12 clk/bit no gap,
// 12 clk/bit with two gap bits, 2 clk/bit for the maximum-length packet),
// a line decoder, a payload RAM model and a CRC reference model.

module tb_vsi_resp_tx;

    logic bb_clk_in = 1'b0;
    always #5 bb_clk_in = ~bb_clk_in;

    logic        rst_h;
    logic [7:0]  marker_v;
    logic [7:0]  flag_v;
    logic [15:0] len_v;
    logic        start_v [3];
    logic        req_w   [3];
    logic [10:0] addr_w  [3];
    logic [7:0]  rdat_r  [3];
    logic        data_w  [3];
    logic        busy_w  [3];
    logic        bd_w    [3];
    logic        done_w  [3];
    logic        lerr_w  [3];
    logic [7:0]  mem [2048];

    int cyc = 0;
    int sel = 0;
    int n_checks = 0;
    int n_errors = 0;

    vsi_resp_tx #(.CLK_PER_BIT(12), .GAP_BITS(0), .MAX_LEN(2032), .AW(11)) u_dut (
        .bb_clk_in(bb_clk_in), .rst_h(rst_h), .start(start_v[0]),
        .marker_in(marker_v), .flag_in(flag_v), .len_in(len_v),
        .pl_rd_req(req_w[0]), .pl_rd_addr(addr_w[0]), .pl_rd_data(rdat_r[0]),
        .DATA(data_w[0]), .busy(busy_w[0]), .byte_done(bd_w[0]), .done(done_w[0]), .len_err(lerr_w[0]));

    vsi_resp_tx #(.CLK_PER_BIT(12), .GAP_BITS(2), .MAX_LEN(2032), .AW(11)) u_gap (
        .bb_clk_in(bb_clk_in), .rst_h(rst_h), .start(start_v[1]),
        .marker_in(marker_v), .flag_in(flag_v), .len_in(len_v),
        .pl_rd_req(req_w[1]), .pl_rd_addr(addr_w[1]), .pl_rd_data(rdat_r[1]),
        .DATA(data_w[1]), .busy(busy_w[1]), .byte_done(bd_w[1]), .done(done_w[1]), .len_err(lerr_w[1]));

    vsi_resp_tx #(.CLK_PER_BIT(2), .GAP_BITS(0), .MAX_LEN(2032), .AW(11)) u_long (
        .bb_clk_in(bb_clk_in), .rst_h(rst_h), .start(start_v[2]),
        .marker_in(marker_v), .flag_in(flag_v), .len_in(len_v),
        .pl_rd_req(req_w[2]), .pl_rd_addr(addr_w[2]), .pl_rd_data(rdat_r[2]),
        .DATA(data_w[2]), .busy(busy_w[2]), .byte_done(bd_w[2]), .done(done_w[2]), .len_err(lerr_w[2]));

    // Cycle counter and payload RAM with one-cycle read latency.
    always @(posedge bb_clk_in) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (req_w[i]) rdat_r[i] <= mem[addr_w[i]];
        end
    end

    logic        data_m, busy_m, bd_m, done_m, lerr_m, req_m;
    logic [10:0] addr_m;
    always_comb begin
        data_m = data_w[sel];
        busy_m = busy_w[sel];
        bd_m   = bd_w[sel];
        done_m = done_w[sel];
        lerr_m = lerr_w[sel];
        req_m  = req_w[sel];
        addr_m = addr_w[sel];
    end

    // Event monitor on the selected instance.
    int rd_q[$];
    int bd_cnt = 0, done_cnt = 0, done_cyc = 0, last_bd_cyc = 0;
    always @(negedge bb_clk_in) begin
        if (req_m) rd_q.push_back(int'(addr_m));
        if (bd_m) begin
            bd_cnt      <= bd_cnt + 1;
            last_bd_cyc <= cyc;
        end
        if (done_m) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    int rd_base, bd_base, done_base, start_cyc;
    logic [7:0] exp_q[$];
    logic       par_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference CRC-16/CCITT, one data bit at a time.
    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic expect_pkt(input logic [7:0] mk, input logic [7:0] fl, input logic [15:0] ln);
        logic [15:0] c;
        exp_q.delete();
        exp_q.push_back(mk);
        exp_q.push_back(fl);
        exp_q.push_back(ln[15:8]);
        exp_q.push_back(ln[7:0]);
        for (int i = 0; i < int'(ln); i++) exp_q.push_back(mem[i]);
        c = 16'hFFFF;
        for (int i = 0; i < exp_q.size(); i++) c = crc_model(c, exp_q[i]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
    endtask

    task automatic mark_bases();
        rd_base   = rd_q.size();
        bd_base   = bd_cnt;
        done_base = done_cnt;
    endtask

    task automatic pulse_start(input int s);
        @(negedge bb_clk_in);
        start_v[s] = 1'b1;
        start_cyc  = cyc;
        @(negedge bb_clk_in);
        start_v[s] = 1'b0;
    endtask

    // Decode exp_q.size() frames from the selected line and compare them.
    task automatic rx_frames(input int cpb, input int gapb, output int first);
        int prev, t;
        logic [7:0] b;
        logic p;
        par_q.delete();
        first = 0;
        prev  = 0;
        for (int f = 0; f < exp_q.size(); f++) begin
            t = 0;
            while (data_m !== 1'b0 && t < 4000) begin
                @(negedge bb_clk_in);
                t++;
            end
            if (data_m !== 1'b0) begin
                check_eq("rx_start_found", {31'd0, data_m}, 32'd0);
                return;
            end
            if (f == 0) first = cyc;
            else check_eq($sformatf("frame_spacing%0d", f), cyc - prev, (11 + gapb) * cpb);
            prev = cyc;
            repeat (cpb / 2) @(negedge bb_clk_in);
            check_eq("start_bit", {31'd0, data_m}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (cpb) @(negedge bb_clk_in);
                b[i] = data_m;
            end
            repeat (cpb) @(negedge bb_clk_in);
            p = data_m;
            repeat (cpb) @(negedge bb_clk_in);
            check_eq("stop_bit", {31'd0, data_m}, 32'd1);
            check_eq($sformatf("byte%0d", f), {24'd0, b}, {24'd0, exp_q[f]});
            check_eq($sformatf("parity%0d", f), {31'd0, p}, {31'd0, ~^exp_q[f]});
            par_q.push_back(p);
        end
    endtask

    task automatic check_tail(input int ln, input int cpb, input int gapb, input int first);
        int t;
        t = 0;
        while (done_cnt == done_base && t < 1000) begin
            @(negedge bb_clk_in);
            t++;
        end
        check_eq("done_count", done_cnt - done_base, 1);
        check_eq("done_latency", done_cyc - first, (6 + ln) * (11 + gapb) * cpb);
        check_eq("byte_done_last", done_cyc - last_bd_cyc, 1);
        check_eq("byte_done_count", bd_cnt - bd_base, 6 + ln);
        check_eq("busy_after_done", {31'd0, busy_m}, 32'd0);
        check_eq("rd_count", rd_q.size() - rd_base, ln);
        for (int i = 0; i < ln && (rd_base + i) < rd_q.size(); i++)
            check_eq("rd_addr", rd_q[rd_base + i], i);
    endtask

    task automatic run_pkt(input int s, input logic [7:0] mk, input logic [7:0] fl,
                           input logic [15:0] ln, input int cpb, input int gapb);
        int first;
        sel      = s;
        marker_v = mk;
        flag_v   = fl;
        len_v    = ln;
        expect_pkt(mk, fl, ln);
        @(negedge bb_clk_in);
        mark_bases();
        pulse_start(s);
        rx_frames(cpb, gapb, first);
        check_eq("first_start_bit", first - start_cyc, 1);
        check_tail(int'(ln), cpb, gapb, first);
    endtask

    initial begin
        #(2000000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first1, first2, d_cyc, t;
        logic [15:0] c;
        logic [7:0] ref_str [9];

        rst_h = 1'b1;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
        marker_v = 8'h00;
        flag_v   = 8'h00;
        len_v    = 16'h0000;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        repeat (3) @(negedge bb_clk_in);

        // Reset state
        check_eq("rst_data", {31'd0, data_m}, 32'd1);
        check_eq("rst_busy", {31'd0, busy_m}, 32'd0);
        check_eq("rst_done", {31'd0, done_m}, 32'd0);
        check_eq("rst_byte_done", {31'd0, bd_m}, 32'd0);
        check_eq("rst_len_err", {31'd0, lerr_m}, 32'd0);
        check_eq("rst_rd_req", {31'd0, req_m}, 32'd0);
        check_eq("rst_rd_addr", {21'd0, addr_m}, 32'd0);
        rst_h = 1'b0;

        // Reference CRC model sanity: "123456789" -> 0x29B1
        for (int i = 0; i < 9; i++) ref_str[i] = 8'h31 + 8'(i);
        c = 16'hFFFF;
        for (int i = 0; i < 9; i++) c = crc_model(c, ref_str[i]);
        check_eq("crc_model_123456789", {16'd0, c}, 32'h0000_29B1);

        // Status packet, no payload
        run_pkt(0, 8'hB6, 8'h02, 16'd0, 12, 0);

        // Payload packet RAM[i]=i
        for (int i = 0; i < 4; i++) mem[i] = 8'(i);
        run_pkt(0, 8'hB6, 8'h04, 16'd4, 12, 0);

        // Parity of 0x00, 0xFF, 0x01
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h01;
        run_pkt(0, 8'hB6, 8'h04, 16'd3, 12, 0);
        check_eq("par_count", par_q.size(), 9);
        if (par_q.size() >= 7) begin
            check_eq("par_00", {31'd0, par_q[4]}, 32'd1);
            check_eq("par_ff", {31'd0, par_q[5]}, 32'd1);
            check_eq("par_01", {31'd0, par_q[6]}, 32'd0);
        end

        // Reset during the start bit of payload byte 2 (k=6)
        for (int i = 0; i < 4; i++) mem[i] = 8'h10 * 8'(i + 1);
        sel = 0; marker_v = 8'hB6; flag_v = 8'h04; len_v = 16'd4;
        mark_bases();
        pulse_start(0);
        repeat (6 * 132 + 5) @(negedge bb_clk_in);
        check_eq("pre_reset_line", {31'd0, data_m}, 32'd0);
        rst_h = 1'b1;
        #1;
        check_eq("reset_line", {31'd0, data_m}, 32'd1);
        check_eq("reset_busy", {31'd0, busy_m}, 32'd0);
        repeat (2) @(negedge bb_clk_in);
        rst_h = 1'b0;
        repeat (1000) @(negedge bb_clk_in);
        check_eq("no_done_after_reset", done_cnt - done_base, 0);
        check_eq("idle_line_after_reset", {31'd0, data_m}, 32'd1);
        run_pkt(0, 8'hB6, 8'h04, 16'd4, 12, 0);

        // Back-to-back: start while busy ignored, start in first IDLE cycle accepted
        sel = 0; marker_v = 8'hB6; flag_v = 8'h01; len_v = 16'd0;
        expect_pkt(8'hB6, 8'h01, 16'd0);
        @(negedge bb_clk_in);
        mark_bases();
        pulse_start(0);
        d_cyc = 0;
        fork
            rx_frames(12, 0, first1);
            begin
                repeat (300) @(negedge bb_clk_in);
                marker_v = 8'h55; flag_v = 8'h55; len_v = 16'd0;
                start_v[0] = 1'b1;
                @(negedge bb_clk_in);
                start_v[0] = 1'b0;
                t = 0;
                while (!done_m && t < 2000) begin
                    @(negedge bb_clk_in);
                    t++;
                end
                d_cyc = cyc;
                marker_v = 8'hA5; flag_v = 8'h07;
                @(negedge bb_clk_in);
                start_v[0] = 1'b1;
                @(negedge bb_clk_in);
                start_v[0] = 1'b0;
            end
        join
        check_eq("b2b_done1", done_cnt - done_base, 1);
        check_eq("b2b_done1_latency", d_cyc - first1, 792);
        expect_pkt(8'hA5, 8'h07, 16'd0);
        mark_bases();
        rx_frames(12, 0, first2);
        check_eq("b2b_restart", first2 - d_cyc, 2);
        check_tail(0, 12, 0, first2);

        // Two gap bits: 24 idle clocks after every stop bit
        run_pkt(1, 8'hB6, 8'h02, 16'd0, 12, 2);

        // Length error, then maximum length
        sel = 2; marker_v = 8'hB6; flag_v = 8'h04; len_v = 16'd2033;
        @(negedge bb_clk_in);
        mark_bases();
        pulse_start(2);
        check_eq("len_err_pulse", {31'd0, lerr_m}, 32'd1);
        check_eq("len_err_busy", {31'd0, busy_m}, 32'd0);
        check_eq("len_err_line", {31'd0, data_m}, 32'd1);
        @(negedge bb_clk_in);
        check_eq("len_err_clear", {31'd0, lerr_m}, 32'd0);
        repeat (40) @(negedge bb_clk_in);
        check_eq("len_err_idle_line", {31'd0, data_m}, 32'd1);
        check_eq("len_err_idle_busy", {31'd0, busy_m}, 32'd0);
        check_eq("len_err_no_done", done_cnt - done_base, 0);

        for (int i = 0; i < 2032; i++) mem[i] = 8'(i * 7 + 3);
        run_pkt(2, 8'hB6, 8'h04, 16'd2032, 2, 0);
        if (rd_q.size() > 0) check_eq("last_rd_addr", rd_q[rd_q.size() - 1], 2031);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
